// File: rtl/mu0_mem_responder.sv
// MU0 bus memory responder: word-addressed RAM with programmable wait states,
// one-cycle rdy completion pulse, and an idle-time side-band loader.
module mu0_mem_responder #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              memrq,
  input  logic              rnw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rdy,
  output logic              busy,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_drop
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state_reg, state_next;
  logic [3:0]          cnt_reg, cnt_next;
  logic [ADDR_W-1:0]   req_addr_reg;
  logic                req_rnw_reg;
  logic [DATA_W-1:0]   req_wdata_reg;
  logic [DATA_W-1:0]   rdata_reg;
  logic                rdy_reg, busy_reg, load_drop_reg;

  logic                latch_req, enter_resp, load_ok;
  logic [ADDR_W-1:0]   acc_addr;
  logic                acc_rnw;
  logic [DATA_W-1:0]   acc_wdata;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;

  logic [DATA_W-1:0]   mem [2**ADDR_W];

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    latch_req  = 1'b0;
    enter_resp = 1'b0;
    case (state_reg)
      IDLE: begin
        if (memrq) begin
          latch_req = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_next = RESP;
            enter_resp = 1'b1;
          end else begin
            state_next = WAIT;
            cnt_next   = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_reg == 4'd1) begin
          state_next = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // With zero wait states the access happens on the latching edge itself,
  // so the bus inputs are used directly instead of the request registers.
  always_comb begin
    acc_addr  = latch_req ? addr  : req_addr_reg;
    acc_rnw   = latch_req ? rnw   : req_rnw_reg;
    acc_wdata = latch_req ? wdata : req_wdata_reg;
    load_ok   = load_we && (state_reg == IDLE) && !memrq;
    wr_en     = 1'b0;
    wr_addr   = load_addr;
    wr_data   = load_data;
    if (rst_n) begin
      if (enter_resp && !acc_rnw) begin
        wr_en   = 1'b1;
        wr_addr = acc_addr;
        wr_data = acc_wdata;
      end else if (load_ok) begin
        wr_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      req_addr_reg  <= '0;
      req_rnw_reg   <= 1'b0;
      req_wdata_reg <= '0;
      rdata_reg     <= '0;
      rdy_reg       <= 1'b0;
      busy_reg      <= 1'b0;
      load_drop_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      if (latch_req) begin
        req_addr_reg  <= addr;
        req_rnw_reg   <= rnw;
        req_wdata_reg <= wdata;
      end
      if (enter_resp && acc_rnw) rdata_reg <= mem[acc_addr];
      rdy_reg       <= enter_resp;
      busy_reg      <= (state_next != IDLE);
      load_drop_reg <= load_we && !load_ok;
    end
  end

  assign rdata     = rdata_reg;
  assign rdy       = rdy_reg;
  assign busy      = busy_reg;
  assign load_drop = load_drop_reg;

endmodule

// File: tb/tb_mu0_mem_responder.sv
// Bench for mu0_mem_responder: five instances with WAIT_CYCLES 0,1,2,3,15
// exercised by a vector table plus hand-written multi-cycle sequences.
module tb_mu0_mem_responder;
  localparam int NI = 5;

  logic        clk;
  logic        rst_n     [NI];
  logic        memrq     [NI];
  logic        rnw       [NI];
  logic [11:0] addr      [NI];
  logic [15:0] wdata     [NI];
  logic [15:0] rdata     [NI];
  logic        rdy       [NI];
  logic        busy      [NI];
  logic        load_we   [NI];
  logic [11:0] load_addr [NI];
  logic [15:0] load_data [NI];
  logic        load_drop [NI];

  int checks = 0;
  int errors = 0;

  function automatic int wc(int i);
    return (i == 4) ? 15 : i;
  endfunction

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int WC = (gi == 4) ? 15 : gi;
    mu0_mem_responder #(.ADDR_W(12), .DATA_W(16), .WAIT_CYCLES(WC)) u_dut (
      .clk(clk), .rst_n(rst_n[gi]), .memrq(memrq[gi]), .rnw(rnw[gi]),
      .addr(addr[gi]), .wdata(wdata[gi]), .rdata(rdata[gi]), .rdy(rdy[gi]),
      .busy(busy[gi]), .load_we(load_we[gi]), .load_addr(load_addr[gi]),
      .load_data(load_data[gi]), .load_drop(load_drop[gi])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic load_all(logic [11:0] a, logic [15:0] d);
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      load_we[i] = 1'b1; load_addr[i] = a; load_data[i] = d;
    end
    @(negedge clk);
    for (int i = 0; i < NI; i++) load_we[i] = 1'b0;
  endtask

  // Counts negedges until rdy, bounded; n is the cycle count.
  task automatic wait_rdy(int i, output int n, output int nb);
    logic got;
    n = 0; nb = 0; got = 1'b0;
    while (!got && n < 60) begin
      @(negedge clk);
      n++;
      if (busy[i]) nb++;
      if (rdy[i]) got = 1'b1;
    end
  endtask

  task automatic txn(int i, logic r, logic [11:0] a, logic [15:0] d, logic [15:0] e);
    int n, nb;
    @(negedge clk);
    memrq[i] = 1'b1; rnw[i] = r; addr[i] = a; wdata[i] = d;
    @(posedge clk);
    #1 memrq[i] = 1'b0;
    wait_rdy(i, n, nb);
    chk("txn_latency", n, wc(i) + 1);
    chk("txn_rdata", {16'h0, rdata[i]}, {16'h0, e});
    chk("txn_busy_cycles", nb, wc(i) + 1);
    @(negedge clk);
    chk("txn_idle_after", {30'h0, rdy[i], busy[i]}, 0);
    $display("txn inst=%0d wait=%0d rnw=%0d addr=%h rdata=%h latency=%0d",
             i, wc(i), r, a, rdata[i], n);
  endtask

  typedef struct {
    int          inst;
    logic        rnw;
    logic [11:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int n, nb;
    vecs[0] = '{1, 1'b1, 12'h0A5, 16'h0000, 16'h1234};
    vecs[1] = '{1, 1'b0, 12'h0A5, 16'h4321, 16'h1234};
    vecs[2] = '{1, 1'b1, 12'h0A5, 16'h0000, 16'h4321};
    vecs[3] = '{0, 1'b1, 12'h010, 16'h0000, 16'h0001};
    vecs[4] = '{2, 1'b1, 12'h100, 16'h0000, 16'h0F0F};
    vecs[5] = '{3, 1'b0, 12'h123, 16'h7777, 16'h0000};
    vecs[6] = '{3, 1'b1, 12'h123, 16'h0000, 16'h7777};
    vecs[7] = '{4, 1'b1, 12'h000, 16'h0000, 16'hA000};
    vecs[8] = '{4, 1'b1, 12'hFFF, 16'h0000, 16'hCFFF};

    for (int i = 0; i < NI; i++) begin
      rst_n[i] = 1'b0; memrq[i] = 1'b0; rnw[i] = 1'b0; addr[i] = '0;
      wdata[i] = '0; load_we[i] = 1'b0; load_addr[i] = '0; load_data[i] = '0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < NI; i++)
      chk("reset_outputs", {12'h0, load_drop[i], rdy[i], busy[i], 1'b0, rdata[i]}, 0);
    for (int i = 0; i < NI; i++) rst_n[i] = 1'b1;

    load_all(12'h0A5, 16'h1234);
    load_all(12'h010, 16'h0001);
    load_all(12'h020, 16'h0002);
    load_all(12'h100, 16'h0F0F);
    load_all(12'h000, 16'hA000);
    load_all(12'hFFF, 16'hCFFF);
    load_all(12'h050, 16'h0550);

    for (int v = 0; v < 9; v++)
      txn(vecs[v].inst, vecs[v].rnw, vecs[v].addr, vecs[v].wdata, vecs[v].exp);

    // WAIT_CYCLES=0, memrq held: write then read back-to-back
    @(negedge clk);
    memrq[0] = 1'b1; rnw[0] = 1'b0; addr[0] = 12'hFFF; wdata[0] = 16'hBEEF;
    @(negedge clk);
    chk("w0_write_rdy", rdy[0], 1);
    chk("w0_write_rdata_hold", rdata[0], 16'h0001);
    rnw[0] = 1'b1;
    @(negedge clk);
    chk("w0_gap_rdy", rdy[0], 0);
    @(negedge clk);
    chk("w0_read_rdy", rdy[0], 1);
    chk("w0_read_rdata", rdata[0], 16'hBEEF);
    memrq[0] = 1'b0;
    $display("txn inst=0 wait=0 write FFF<-BEEF then read rdata=%h", rdata[0]);
    @(negedge clk);
    chk("w0_idle_after", busy[0], 0);

    // WAIT_CYCLES=3: bus inputs change during WAIT
    @(negedge clk);
    memrq[3] = 1'b1; rnw[3] = 1'b1; addr[3] = 12'h010;
    @(posedge clk);
    #1 begin addr[3] = 12'h020; memrq[3] = 1'b0; end
    wait_rdy(3, n, nb);
    chk("w3_latency", n, 4);
    chk("w3_rdata", rdata[3], 16'h0001);
    $display("txn inst=3 wait=3 read 010 with addr changed rdata=%h latency=%0d", rdata[3], n);
    repeat (2) begin
      @(negedge clk);
      chk("w3_no_second_req", {rdy[3], busy[3]}, 0);
    end

    // Loader conflicts on WAIT_CYCLES=1: with memrq in IDLE, then during WAIT
    @(negedge clk);
    memrq[1] = 1'b1; rnw[1] = 1'b1; addr[1] = 12'h050;
    load_we[1] = 1'b1; load_addr[1] = 12'h0A5; load_data[1] = 16'hDEAD;
    @(negedge clk);
    chk("drop_idle_memrq", load_drop[1], 1);
    chk("drop_state_wait", busy[1], 1);
    memrq[1] = 1'b0; load_data[1] = 16'hBAD0;
    @(negedge clk);
    chk("drop_during_wait", load_drop[1], 1);
    chk("conflict_rdy", rdy[1], 1);
    chk("conflict_rdata", rdata[1], 16'h0550);
    load_we[1] = 1'b0;
    @(negedge clk);
    chk("drop_clears", load_drop[1], 0);
    txn(1, 1'b1, 12'h0A5, 16'h0000, 16'h4321);

    // Reset during WAIT aborts a write on WAIT_CYCLES=2
    @(negedge clk);
    memrq[2] = 1'b1; rnw[2] = 1'b0; addr[2] = 12'h100; wdata[2] = 16'h5555;
    @(negedge clk);
    chk("rst_pre_busy", busy[2], 1);
    memrq[2] = 1'b0;
    rst_n[2] = 1'b0;
    #1;
    chk("rst_mid_outputs", {14'h0, rdy[2], busy[2], rdata[2]}, 0);
    @(negedge clk);
    rst_n[2] = 1'b1;
    txn(2, 1'b1, 12'h100, 16'h0000, 16'h0F0F);

    // WAIT_CYCLES=15: addresses 000 and FFF back-to-back with memrq held
    @(negedge clk);
    memrq[4] = 1'b1; rnw[4] = 1'b1; addr[4] = 12'h000;
    wait_rdy(4, n, nb);
    chk("w15_first_latency", n, 16);
    chk("w15_first_rdata", rdata[4], 16'hA000);
    addr[4] = 12'hFFF;
    wait_rdy(4, n, nb);
    chk("w15_second_spacing", n, 17);
    chk("w15_second_rdata", rdata[4], 16'hCFFF);
    memrq[4] = 1'b0;
    $display("txn inst=4 wait=15 back-to-back 000/FFF rdata=%h spacing=%0d", rdata[4], n);
    @(negedge clk);
    @(negedge clk);
    chk("w15_idle_after", busy[4], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
